axis_stall_detector: RTL and testbench
======================================

AXIS_STALL_DETECTOR -- requirements
Module: axis_stall_detector

Interface
REQ-001 Parameter NUM_CH, default 5, number of monitored AXI-Stream channels.
REQ-002 Parameter CNT_W, default 16, width of each per-channel stall counter.
REQ-003 Parameter STALL_THRESH, default 1000, consecutive stall cycles before a channel is declared blocked; legal range 1..2^CNT_W-1.
REQ-004 clock  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  monitoring enable; low freezes all state and counters.
REQ-007 clear  input  1  synchronous clear of first-block latch and event counter.
REQ-008 tvalid  input  NUM_CH  per-channel TVALID, bit i = channel i.
REQ-009 tready  input  NUM_CH  per-channel TREADY.
REQ-010 inst_idle  input  NUM_CH  per-channel owning-instance idle flag.
REQ-011 axis_block_sigs  output  NUM_CH  per-channel blocked flag, registered.
REQ-012 first_block_vld  output  1  a block has been recorded since reset/clear.
REQ-013 first_block_ch  output  $clog2(NUM_CH)  index of the first channel that blocked.
REQ-014 block_events  output  8  saturating count of BLOCK-state entries.

Function
REQ-015 Per channel i, a transfer cycle is tvalid[i]&tready[i]; a stall cycle is enable & ~inst_idle[i] & ~(tvalid[i]&tready[i]).
REQ-016 Each channel has a 4-state FSM: IDLE, RUN, STALL, BLOCK.
REQ-017 When enable=1, inst_idle[i]=1 moves any state to IDLE and zeroes cnt[i]; this has priority over all other transitions.
REQ-018 From IDLE, inst_idle[i]=0 moves to RUN; cnt[i] stays 0.
REQ-019 From RUN, a stall cycle moves to STALL with cnt[i]=1; a transfer cycle stays in RUN.
REQ-020 In STALL, a stall cycle increments cnt[i], and a transfer cycle returns to RUN with cnt[i]=0.
REQ-021 In STALL, when the increment makes cnt[i]==STALL_THRESH, the FSM enters BLOCK on that same edge; STALL_THRESH=1 enters BLOCK directly from RUN on the first stall cycle.
REQ-022 In BLOCK, cnt[i] saturates at all-ones; a transfer cycle returns to RUN with cnt[i]=0.
REQ-023 axis_block_sigs[i]=1 exactly while the FSM is in BLOCK; there are no combinational paths from inputs to outputs.
REQ-024 Latency: after T=STALL_THRESH consecutive stall cycles sampled at edges 1..T, axis_block_sigs[i] is high immediately after edge T.
REQ-025 enable=0 holds all FSM states, counters and outputs unchanged, including while in BLOCK.
REQ-026 On the first edge where any channel enters BLOCK while first_block_vld=0, first_block_vld<=1 and first_block_ch<=the lowest-indexed channel entering BLOCK on that edge.
REQ-027 first_block_ch/vld are held until reset or clear; later blocks do not overwrite them.
REQ-028 block_events adds the number of channels entering BLOCK on each edge and saturates at 255.
REQ-029 clear=1 zeroes first_block_vld, first_block_ch and block_events and does not affect FSMs or counters.
REQ-030 clear takes priority over a simultaneous BLOCK entry on the same edge, so that entry is not recorded.

Reset
REQ-031 With reset=1, every FSM goes to IDLE, and every cnt[i], axis_block_sigs, first_block_vld, first_block_ch and block_events go to 0 on the next edge, regardless of enable.
REQ-032 Reset asserted mid-stall or in BLOCK discards all history, so that counting restarts from 0 after release.

Verification
REQ-033 STALL_THRESH=4, ch0 inst_idle=0, tvalid=1, tready=0 for 4 cycles -> axis_block_sigs=5'b00001 after edge 4, first_block_ch=0, block_events=1.
REQ-034 ch2 stalls 3 cycles, transfers 1 cycle, then stalls 3 cycles (thresh 4) -> axis_block_sigs[2] never asserts.
REQ-035 ch1 and ch3 reach threshold on the same edge -> axis_block_sigs=5'b01010, first_block_ch=1, block_events=2.
REQ-036 ch4 in BLOCK, then enable=0 for 10 cycles, then inst_idle[4]=1 with enable=1 -> block held 10 cycles, then cleared the next edge.
REQ-037 clear=1 on the same edge as ch0 enters BLOCK -> axis_block_sigs[0]=1, first_block_vld=0, block_events=0.
REQ-038 reset pulse while ch0 cnt=3, then resume stall -> block asserts only after 4 further stall cycles.

Source files
------------

// File: rtl/axis_stall_detector.sv
// axis_stall_detector: per-channel AXI-Stream stall watchdog with first-block capture
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous active-high reset
//   enable           monitoring enable; low freezes all state
//   clear            clears first-block capture and event counter
//   tvalid/tready    per-channel handshake, bit i = channel i
//   inst_idle        per-channel owning-instance idle flag
//   axis_block_sigs  per-channel blocked flag (registered)
//   first_block_vld  a block has been captured since reset/clear
//   first_block_ch   lowest channel index of the first captured block
//   block_events     saturating count of BLOCK entries
module axis_stall_detector #(
    parameter int NUM_CH       = 5,
    parameter int CNT_W        = 16,
    parameter int STALL_THRESH = 1000
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     clear,
    input  logic [NUM_CH-1:0]                        tvalid,
    input  logic [NUM_CH-1:0]                        tready,
    input  logic [NUM_CH-1:0]                        inst_idle,
    output logic [NUM_CH-1:0]                        axis_block_sigs,
    output logic                                     first_block_vld,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] first_block_ch,
    output logic [7:0]                               block_events
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] THR = CNT_W'(STALL_THRESH);

    typedef enum logic [1:0] {IDLE, RUN, STALL, BLOCK} state_t;

    state_t             state_q [NUM_CH];
    state_t             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]  xfer, stall, enter;
    logic               first_vld_q, first_vld_d;
    logic [CH_W-1:0]    first_ch_q, first_ch_d, low_ch;
    logic [7:0]         events_q, events_d;
    logic [31:0]        ev_sum;

    // enable gating is applied in the FSM, so stall here only excludes idle/transfer
    assign xfer  = tvalid & tready;
    assign stall = ~inst_idle & ~xfer;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
            events_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
            events_q    <= events_d;
        end
    end

    always_comb begin
        enter = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (enable) begin
                if (inst_idle[i]) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else begin
                    case (state_q[i])
                        IDLE: begin
                            state_d[i] = RUN;
                            cnt_d[i]   = '0;
                        end
                        RUN: if (stall[i]) begin
                            cnt_d[i]   = CNT_W'(1);
                            state_d[i] = STALL_THRESH == 1 ? BLOCK : STALL;
                        end
                        STALL: begin
                            cnt_d[i]   = xfer[i] ? '0 : cnt_q[i] + CNT_W'(1);
                            state_d[i] = xfer[i] ? RUN : (cnt_q[i] + CNT_W'(1) == THR ? BLOCK : STALL);
                        end
                        default: begin
                            cnt_d[i]   = xfer[i] ? '0 : (&cnt_q[i] ? cnt_q[i] : cnt_q[i] + CNT_W'(1));
                            state_d[i] = xfer[i] ? RUN : BLOCK;
                        end
                    endcase
                end
            end
            enter[i] = state_d[i] == BLOCK && state_q[i] != BLOCK;
        end
    end

    // first-block capture and event counting; clear wins over a same-edge entry
    always_comb begin
        ev_sum = 32'(events_q);
        low_ch = '0;
        for (int i = 0; i < NUM_CH; i++) ev_sum = ev_sum + 32'(enter[i]);
        for (int i = NUM_CH - 1; i >= 0; i--) if (enter[i]) low_ch = CH_W'(i);
        first_vld_d = clear ? 1'b0 : first_vld_q | (|enter);
        first_ch_d  = clear ? '0 : (!first_vld_q && |enter) ? low_ch : first_ch_q;
        events_d    = clear ? '0 : (ev_sum > 32'd255 ? 8'hff : ev_sum[7:0]);
    end

    always_comb begin
        axis_block_sigs = '0;
        for (int i = 0; i < NUM_CH; i++) axis_block_sigs[i] = state_q[i] == BLOCK;
    end

    assign first_block_vld = first_vld_q;
    assign first_block_ch  = first_ch_q;
    assign block_events    = events_q;
endmodule

// File: tb/tb_axis_stall_detector.sv
// tb_axis_stall_detector: directed vector check of axis_stall_detector with threshold 4
module tb_axis_stall_detector;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] tvalid = '0;
    logic [4:0] tready = '0;
    logic [4:0] inst_idle = '0;
    logic [4:0] axis_block_sigs;
    logic       first_block_vld;
    logic [2:0] first_block_ch;
    logic [7:0] block_events;
    int         total = 0;
    int         passed = 0;

    typedef struct {
        logic       rst, en, clr;
        logic [4:0] tv, tr, idl;
        logic [4:0] eb;
        logic       evld;
        logic [2:0] ech;
        logic [7:0] eev;
    } vec_t;

    vec_t tbl[$];

    axis_stall_detector #(.NUM_CH(5), .CNT_W(16), .STALL_THRESH(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .tvalid(tvalid), .tready(tready), .inst_idle(inst_idle),
        .axis_block_sigs(axis_block_sigs), .first_block_vld(first_block_vld),
        .first_block_ch(first_block_ch), .block_events(block_events)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, en, clr, input logic [4:0] tr, idl, eb,
                                input logic evld, input logic [2:0] ech, input logic [7:0] eev);
        vec_t v;
        v = '{rst, en, clr, 5'h1f, tr, idl, eb, evld, ech, eev};
        return v;
    endfunction

    task automatic step(input vec_t v, input string nm);
        @(negedge clock);
        reset = v.rst; enable = v.en; clear = v.clr;
        tvalid = v.tv; tready = v.tr; inst_idle = v.idl;
        @(posedge clock);
        #1;
        total++;
        if (axis_block_sigs === v.eb && first_block_vld === v.evld &&
            first_block_ch === v.ech && block_events === v.eev)
            passed++;
        else
            $display("FAIL %s: got blk=%b vld=%b ch=%0d ev=%0d, want blk=%b vld=%b ch=%0d ev=%0d",
                     nm, axis_block_sigs, first_block_vld, first_block_ch, block_events,
                     v.eb, v.evld, v.ech, v.eev);
    endtask

    initial begin
        // reset with enable low, then all idle, then all running
        tbl.push_back(mk(1, 0, 0, 5'h00, 5'h00, 5'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'h1f, 5'h1f, 5'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'h1f, 5'h00, 5'h00, 0, 0, 0));
        // ch0 stalls 4 cycles
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 5'h1e, 5'h00, 5'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'h1e, 5'h00, 5'h01, 1, 0, 1));
        // ch2: 3 stalls, transfer, 3 stalls -> never blocks (ch0 stays blocked)
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 5'h1a, 5'h00, 5'h01, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 5'h1e, 5'h00, 5'h01, 1, 0, 1));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 5'h1a, 5'h00, 5'h01, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 5'h1f, 5'h00, 5'h00, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 5'h1f, 5'h00, 5'h00, 0, 0, 0));
        // ch1 and ch3 block on the same edge
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 5'h15, 5'h00, 5'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'h15, 5'h00, 5'h0a, 1, 1, 2));
        // later ch4 block does not overwrite first_block_ch
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 5'h05, 5'h00, 5'h0a, 1, 1, 2));
        tbl.push_back(mk(0, 1, 0, 5'h05, 5'h00, 5'h1a, 1, 1, 3));
        // clear coinciding with ch0 BLOCK entry drops that entry
        tbl.push_back(mk(0, 1, 1, 5'h1f, 5'h00, 5'h00, 0, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 5'h1e, 5'h00, 5'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 5'h1e, 5'h00, 5'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'h1e, 5'h00, 5'h01, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 5'h1f, 5'h1f, 5'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // ch4 blocks, enable low 10 cycles with idle/transfer inputs, then idle clears it
        step(mk(0, 1, 0, 5'h1f, 5'h00, 5'h00, 0, 0, 0), "run_all");
        for (int k = 0; k < 3; k++) step(mk(0, 1, 0, 5'h0f, 5'h00, 5'h00, 0, 0, 0), "ch4_stall");
        step(mk(0, 1, 0, 5'h0f, 5'h00, 5'h10, 1, 4, 1), "ch4_block");
        for (int k = 0; k < 10; k++) step(mk(0, 0, 0, 5'h1f, 5'h1f, 5'h10, 1, 4, 1), $sformatf("hold%0d", k));
        step(mk(0, 1, 0, 5'h1f, 5'h10, 5'h00, 1, 4, 1), "ch4_idle");

        // reset at ch0 cnt=3 discards history
        step(mk(0, 1, 0, 5'h1f, 5'h00, 5'h00, 1, 4, 1), "run_again");
        for (int k = 0; k < 3; k++) step(mk(0, 1, 0, 5'h1e, 5'h00, 5'h00, 1, 4, 1), "pre_rst_stall");
        step(mk(1, 1, 0, 5'h1e, 5'h00, 5'h00, 0, 0, 0), "mid_reset");
        step(mk(0, 1, 0, 5'h1f, 5'h00, 5'h00, 0, 0, 0), "post_rst_run");
        for (int k = 0; k < 3; k++) step(mk(0, 1, 0, 5'h1e, 5'h00, 5'h00, 0, 0, 0), $sformatf("post_rst_stall%0d", k));
        step(mk(0, 1, 0, 5'h1e, 5'h00, 5'h01, 1, 0, 1), "post_rst_block");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
